// File: rtl/jtag_user_regs.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_user_regs
//  Description : Addressed read/write register bank behind a BSCANE2 USER
//                chain. TAP pins are oversampled in the clk_p domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_user_regs #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 4,
    parameter int                NREGS   = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk_p,
    input  logic                    rst,
    input  logic                    jtag_tck,
    input  logic                    jtag_tdi,
    input  logic                    jtag_sel,
    input  logic                    jtag_capture,
    input  logic                    jtag_shift,
    input  logic                    jtag_update,
    input  logic                    jtag_reset,
    output logic                    jtag_tdo,
    input  logic [DATA_W-1:0]       i_stat,
    output logic [NREGS*DATA_W-1:0] o_regs,
    output logic                    o_wr_stb,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic                    o_frame_err
);

    localparam int L     = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(L + 1);

    localparam int B_TCK = 0;
    localparam int B_TDI = 1;
    localparam int B_SEL = 2;
    localparam int B_CAP = 3;
    localparam int B_SHF = 4;
    localparam int B_UPD = 5;
    localparam int B_RST = 6;

    logic [6:0]        pins_w;
    logic [6:0]        sync1_q;
    logic [6:0]        sync2_q;
    logic              tck_dly_q;
    logic              upd_dly_q;
    logic              tck_rise_w;
    logic              upd_rise_w;

    logic [L-1:0]      sr_q,      sr_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic              err_q,     err_d;
    logic              stb_q,     stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              tdo_q;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] rd_val_w;
    logic [DATA_W-1:0] sr_data_w;
    logic [ADDR_W-1:0] sr_addr_w;
    logic              sr_wr_w;

    assign pins_w = {jtag_reset, jtag_update, jtag_shift, jtag_capture,
                     jtag_sel, jtag_tdi, jtag_tck};

    // Edges come from the synchronised level against its one-cycle-old copy.
    assign tck_rise_w = sync2_q[B_TCK] & ~tck_dly_q;
    assign upd_rise_w = sync2_q[B_UPD] & ~upd_dly_q;

    assign sr_data_w = sr_q[DATA_W-1:0];
    assign sr_addr_w = sr_q[DATA_W+ADDR_W-1:DATA_W];
    assign sr_wr_w   = sr_q[L-1];

    always_comb begin
        rd_val_w = '0;
        if (rd_ptr_q == '0) begin
            rd_val_w = i_stat;
        end
        for (int k = 0; k < NREGS; k++) begin
            if (rd_ptr_q == ADDR_W'(k + 1)) begin
                rd_val_w = regs_q[k];
            end
        end
    end

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;
        stb_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        for (int k = 0; k < NREGS; k++) begin
            regs_d[k] = regs_q[k];
        end

        if (sync2_q[B_RST]) begin
            sr_d     = '0;
            cnt_d    = '0;
            rd_ptr_d = '0;
            err_d    = 1'b0;
        end else if (sync2_q[B_SEL]) begin
            if (upd_rise_w) begin
                if (cnt_q != CNT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    rd_ptr_d = sr_addr_w;
                    // Address 0 and addresses past the bank never match here,
                    // so such writes fall away without a strobe.
                    for (int k = 0; k < NREGS; k++) begin
                        if (sr_wr_w && (sr_addr_w == ADDR_W'(k + 1))) begin
                            regs_d[k] = sr_data_w;
                            stb_d     = 1'b1;
                            wr_addr_d = sr_addr_w;
                        end
                    end
                end
                cnt_d = '0;
            end else if (tck_rise_w) begin
                if (sync2_q[B_CAP]) begin
                    sr_d  = {1'b0, rd_ptr_q, rd_val_w};
                    cnt_d = '0;
                end else if (sync2_q[B_SHF]) begin
                    sr_d = {sync2_q[B_TDI], sr_q[L-1:1]};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            tck_dly_q <= 1'b0;
            upd_dly_q <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
            tdo_q     <= 1'b0;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= RST_VAL;
            end
        end else begin
            sync1_q   <= pins_w;
            sync2_q   <= sync1_q;
            tck_dly_q <= sync2_q[B_TCK];
            upd_dly_q <= sync2_q[B_UPD];
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            wr_addr_q <= wr_addr_d;
            tdo_q     <= sr_q[0];
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
            assign o_regs[g*DATA_W +: DATA_W] = regs_q[g];
        end
    endgenerate

    assign jtag_tdo    = tdo_q;
    assign o_wr_stb    = stb_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_user_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_user_regs
//  Description : Randomised frame-level bench for jtag_user_regs with a
//                behavioural register-bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_user_regs;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 8;
    localparam int L  = 1 + AW + DW;

    logic            clk_p = 1'b0;
    logic            rst   = 1'b1;
    logic            tck   = 1'b0;
    logic            tdi   = 1'b0;
    logic            sel   = 1'b0;
    logic            cap   = 1'b0;
    logic            shf   = 1'b0;
    logic            upd   = 1'b0;
    logic            jrst  = 1'b0;
    logic            jtag_tdo;
    logic [DW-1:0]   i_stat = '0;
    logic [NR*DW-1:0] o_regs;
    logic            o_wr_stb;
    logic [AW-1:0]   o_wr_addr;
    logic            o_frame_err;

    always #5 clk_p = ~clk_p;

    jtag_user_regs #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .RST_VAL('0)) dut (
        .clk_p        (clk_p),
        .rst          (rst),
        .jtag_tck     (tck),
        .jtag_tdi     (tdi),
        .jtag_sel     (sel),
        .jtag_capture (cap),
        .jtag_shift   (shf),
        .jtag_update  (upd),
        .jtag_reset   (jrst),
        .jtag_tdo     (jtag_tdo),
        .i_stat       (i_stat),
        .o_regs       (o_regs),
        .o_wr_stb     (o_wr_stb),
        .o_wr_addr    (o_wr_addr),
        .o_frame_err  (o_frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe observer: counts high cycles and snapshots the bank while high.
    int               stb_total = 0;
    logic [NR*DW-1:0] stb_regs  = '0;
    always @(negedge clk_p) begin
        if (o_wr_stb) begin
            stb_total = stb_total + 1;
            stb_regs  = o_regs;
        end
    end

    // Reference model: the bank as seen by the host.
    logic [DW-1:0] m_regs [NR];
    logic [AW-1:0] m_rdptr;
    logic [AW-1:0] m_wr_addr;
    logic          m_err;
    int            m_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] m_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_regs[k];
        return f;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input logic [DW-1:0] s);
        if (a == 0) return s;
        if (int'(a) <= NR) return m_regs[int'(a) - 1];
        return '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_rdptr   = '0;
        m_wr_addr = '0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_regs"}, 128'(o_regs), 128'(m_flat()));
        check({tag, "_err"}, 128'(o_frame_err), 128'(m_err));
        check({tag, "_waddr"}, 128'(o_wr_addr), 128'(m_wr_addr));
    endtask

    task automatic tck_pulse(input logic c, input logic s, input logic d, output logic seen);
        cap = c;
        shf = s;
        tdi = d;
        clks(5);
        seen = jtag_tdo;
        tck = 1'b1;
        clks(5);
        tck = 1'b0;
    endtask

    task automatic tap_reset();
        jrst = 1'b1;
        clks(5);
        jrst = 1'b0;
        clks(5);
        m_rdptr = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
        check_state("jreset");
    endtask

    // One Capture / Shift*n / Update sequence; rst_at > 0 pulses rst after that many shifts.
    task automatic run_frame(input logic sel_v, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int nshift,
                             input logic [DW-1:0] stat, input int rst_at);
        logic [L-1:0] f, cap_exp, obs, mask;
        logic         seen;
        int           s0, exp_stb, nb;
        f       = {wr, addr, data};
        i_stat  = stat;
        sel     = sel_v;
        obs     = '0;
        cap_exp = {1'b0, m_rdptr, m_read(m_rdptr, stat)};
        tck_pulse(1'b1, 1'b0, 1'b0, seen);
        if (sel_v) m_cnt = 0;
        for (int i = 0; i < nshift; i++) begin
            tck_pulse(1'b0, 1'b1, (i < L) ? f[i] : 1'($urandom), seen);
            if (i < L) obs[i] = seen;
            if (sel_v) m_cnt++;
            if (i + 1 == rst_at) begin
                rst = 1'b1;
                clks(2);
                rst = 1'b0;
                clks(2);
                model_reset();
                check_state("midrst");
                check("midrst_tdo", 128'(jtag_tdo), 128'(0));
            end
        end
        shf = 1'b0;
        cap = 1'b0;
        if (sel_v && rst_at <= 0) begin
            nb   = (nshift < L) ? nshift : L;
            mask = (nb == L) ? '1 : ((L'(1) << nb) - L'(1));
            check("tdo_frame", 128'(obs & mask), 128'(cap_exp & mask));
        end
        s0      = stb_total;
        exp_stb = 0;
        upd = 1'b1;
        clks(5);
        upd = 1'b0;
        clks(5);
        if (sel_v) begin
            if (m_cnt != L) begin
                m_err = 1'b1;
            end else begin
                m_rdptr = addr;
                if (wr && addr != 0 && int'(addr) <= NR) begin
                    m_regs[int'(addr) - 1] = data;
                    m_wr_addr = addr;
                    exp_stb   = 1;
                end
            end
            m_cnt = 0;
        end
        check("stb_count", 128'(stb_total - s0), 128'(exp_stb));
        check_state("frame");
        if (exp_stb == 1) check("stb_regs", 128'(stb_regs), 128'(m_flat()));
    endtask

    initial begin
        int ns;
        model_reset();
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(4);
        check_state("reset");
        check("reset_tdo", 128'(jtag_tdo), 128'(0));
        check("reset_stb", 128'(stb_total), 128'(0));

        run_frame(1'b1, 1'b1, 4'd3, 16'hBEEF, L, 16'h0000, 0);
        run_frame(1'b1, 1'b0, 4'd3, 16'h0000, L, 16'h0000, 0);
        run_frame(1'b1, 1'b0, 4'd0, 16'h0000, L, 16'h0000, 0);
        run_frame(1'b1, 1'b0, 4'd0, 16'h0000, L, 16'h5A5A, 0);

        run_frame(1'b1, 1'b1, 4'd5, 16'h1234, L - 1, 16'h0000, 0);
        tap_reset();

        run_frame(1'b1, 1'b1, 4'd0,  16'h1111, L, 16'h0000, 0);
        run_frame(1'b1, 1'b1, 4'd12, 16'h2222, L, 16'h0000, 0);
        run_frame(1'b1, 1'b0, 4'd12, 16'h0000, L, 16'h3333, 0);

        run_frame(1'b1, 1'b1, 4'd2, 16'h7777, L, 16'h0000, 10);
        run_frame(1'b0, 1'b1, 4'd4, 16'hABCD, L, 16'h0000, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       ns = L - 1;
                1:       ns = L + 1;
                2:       ns = L + 4;
                3:       ns = 5;
                default: ns = L;
            endcase
            if ($urandom_range(0, 7) == 0) tap_reset();
            run_frame(($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
                      16'($urandom), ns, 16'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_user_regs.md
# jtag_user_regs

Parametrised JTAG user-register bank driven by the signals of a BSCANE2 USER chain. It replaces the single fixed 16-bit shift register with an addressed frame. Each frame carries a write flag, an address and a data word, so a host can read status and read or write up to NREGS control registers. All TAP signals are oversampled and synchronised into the clk_p domain; no logic runs on TCK.

## Interface
- DATA_W, 16: data field and register width.
- ADDR_W, 4: address field width.
- NREGS, 8: number of read/write registers; must satisfy 1 ≤ NREGS ≤ 2^ADDR_W − 1.
- RST_VAL, 0: reset value of every read/write register, DATA_W bits.
- clk_p  in  1  system clock; must be ≥ 8× TCK frequency.
- rst  in  1  synchronous, active-high reset.
- jtag_tck, jtag_tdi, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset  in  1 each  BSCANE2 outputs; asynchronous to clk_p.
- jtag_tdo  out  1  to BSCANE2 TDO.
- i_stat  in  DATA_W  read-only status word (DIP switches), read at address 0.
- o_regs  out  NREGS*DATA_W  register k occupies bits [k*DATA_W +: DATA_W] and is at address k+1.
- o_wr_stb  out  1  one-cycle pulse on every accepted write.
- o_wr_addr  out  ADDR_W  address of the last accepted write.
- o_frame_err  out  1  sticky flag for a malformed frame.

## Operation
- Frame length L = 1 + ADDR_W + DATA_W. Shift register sr[L-1:0] holds data in [DATA_W-1:0], addr in [DATA_W+ADDR_W-1:DATA_W] and wr in [L-1].
- Every jtag_* input passes through a 2-flop synchroniser. tck_rise and upd_rise are formed from the synchronised value and a 1-cycle delayed copy.
- On tck_rise with sel=1:
  - If capture=1: sr.data gets the read value at rd_ptr, sr.addr gets rd_ptr, sr.wr gets 0, and cnt is cleared.
  - Else if shift=1: sr gets {tdi, sr[L-1:1]} and cnt increments, saturating at L+1.
  - capture has priority over shift.
- Read value at an address:
  - address 0 returns i_stat as sampled on the capture cycle.
  - addresses 1..NREGS return the register.
  - addresses above NREGS return 0.
- jtag_tdo is a registered copy of sr[0], refreshed every cycle. The host sees bit 0 of the data field first.
- On upd_rise with sel=1:
  - If cnt ≠ L: no write, rd_ptr unchanged, o_frame_err set to 1, cnt cleared.
  - Else rd_ptr gets sr.addr. If sr.wr=1 and 1 ≤ addr ≤ NREGS, the register gets sr.data, o_wr_stb=1 for one cycle and o_wr_addr gets addr.
  - A write to address 0 or above NREGS is dropped silently: no strobe, no error, rd_ptr still updated.
  - cnt is cleared.
- Synchronised jtag_reset=1 clears sr, cnt, rd_ptr and o_frame_err. o_regs is retained.
- rst=1 clears everything and has priority over every TAP event.
- Any event with sel=0 is ignored, so other USER chains do not disturb the block.

## Timing
- Reset values: o_regs = RST_VAL in every slot, o_wr_stb=0, o_wr_addr=0, o_frame_err=0, jtag_tdo=0. sr, cnt, rd_ptr and the synchronisers are also 0.
- Pin to action latency: an edge on a jtag_* pin first sampled at clk_p edge n is acted on at edge n+2. The resulting register update is visible after edge n+2.
- jtag_tdo is valid 1 clk_p cycle after the action. With TCK low ≥ 4 clk_p periods, TDO is stable well before the next TCK rise.
- TCK high and TCK low must each last ≥ 4 clk_p periods. Violating this is out of scope; no detection is required.
- o_wr_stb is high for exactly 1 cycle, coincident with the first cycle the new o_regs value is visible.
- Back-to-back frames (Update then Capture with no Run-Test/Idle) must work.
- An update that arrives while cnt has saturated is an error, like any other cnt ≠ L.

## Test plan
Parameters for all scenarios: DATA_W=16, ADDR_W=4, NREGS=8, L=21.
- Reset: hold rst for 2 cycles, then idle. Required: o_regs=0, jtag_tdo=0, o_frame_err=0, no o_wr_stb.
- Write: frame wr=1, addr=3, data=0xBEEF, 21 shifts, then Update. Required: o_regs[47:32]=0xBEEF, one o_wr_stb with o_wr_addr=3, all other slots unchanged.
- Read-back: Capture, then 21 shifts. Required: TDO bits 0..15 give 0xBEEF LSB first, bits 16..19 give 3, bit 20 gives 0. Then read address 0 with i_stat=0x5A5A; required: TDO bits 0..15 give 0x5A5A.
- Short frame: 20 shifts with wr=1, then Update. Required: o_frame_err=1, no write, no strobe. Then assert jtag_reset. Required: o_frame_err=0 and o_regs still holds 0xBEEF.
- Out-of-range write: frame wr=1 with addr 0, then a second frame wr=1 with addr 12. Required: no o_regs change, no strobe, no error. A following capture of addr 12 returns data field 0.
- Reset mid-frame and sel gating:
  - Assert rst after 10 shifts. Required: all state is 0 and the completed frame is then rejected as an error.
  - Run a full write with sel=0. Required: the frame is fully ignored.
